// File: rtl/microwave_timer_ctrl.sv
// Microwave countdown sequencer: keypad digit loading, cook/pause/done
// control, one-second prescaler and magnetron gating for a 3-digit counter.
module microwave_timer_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DONE_CYCLES   = 100_000_000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       zero,
  output logic [3:0] cnt_data,
  output logic       cnt_loadn,
  output logic       cnt_clrn,
  output logic       cnt_enable,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam int DW = $clog2(DONE_CYCLES + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DONE_MAX = DW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    digit_cnt, digit_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [DW-1:0] done_cnt, done_nxt;
  logic [3:0]    data_q;
  logic          loadn_q;
  logic          clr_pulse;
  logic          key_ok;
  logic          go_ok;
  logic          accept;
  logic          clr_req;
  logic          in_cook;

  assign key_ok = key_valid && (key_data <= 4'd9) && (digit_cnt != 2'd3);
  assign go_ok  = start && door_closed && !zero;

  always_comb begin
    state_nxt = state;
    digit_nxt = digit_cnt;
    tick_nxt  = tick_cnt;
    done_nxt  = done_cnt;
    accept    = 1'b0;
    clr_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_ok) begin
          accept    = 1'b1;
          digit_nxt = 2'd1;
          state_nxt = ENTRY;
        end
      end
      ENTRY: begin
        if (stop) begin
          clr_req   = 1'b1;
          digit_nxt = 2'd0;
          state_nxt = IDLE;
        end else begin
          if (key_ok) begin
            accept    = 1'b1;
            digit_nxt = digit_cnt + 2'd1;
          end
          if (go_ok) state_nxt = COOK;
        end
      end
      COOK: begin
        if (zero) begin
          tick_nxt  = '0;
          digit_nxt = 2'd0;
          done_nxt  = '0;
          state_nxt = DONE;
        end else if (stop || !door_closed) begin
          // leave tick_cnt untouched so the second resumes mid-way
          state_nxt = PAUSE;
        end else if (tick_cnt == TICK_MAX) begin
          tick_nxt = '0;
        end else begin
          tick_nxt = tick_cnt + TW'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          clr_req   = 1'b1;
          digit_nxt = 2'd0;
          tick_nxt  = '0;
          state_nxt = IDLE;
        end else if (go_ok) begin
          state_nxt = COOK;
        end
      end
      DONE: begin
        if (key_valid || stop || done_cnt == DONE_MAX) begin
          done_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          done_nxt = done_cnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      digit_cnt <= 2'd0;
      tick_cnt  <= '0;
      done_cnt  <= '0;
      data_q    <= 4'd0;
      loadn_q   <= 1'b1;
      clr_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      digit_cnt <= digit_nxt;
      tick_cnt  <= tick_nxt;
      done_cnt  <= done_nxt;
      loadn_q   <= ~accept;
      clr_pulse <= clr_req;
      if (accept) data_q <= key_data;
    end
  end

  assign in_cook    = (state == COOK);
  assign cnt_data   = data_q;
  assign cnt_loadn  = loadn_q;
  // chain stays cleared for the whole reset, not only on the pulse
  assign cnt_clrn   = clrn & ~clr_pulse;
  assign cnt_enable = in_cook & door_closed & (tick_cnt == TICK_MAX);
  assign mag_on     = in_cook & door_closed;
  assign done       = (state == DONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed vector table, reset-in-cook
// sequence, then random stimulus against a behavioural model.
module tb_microwave_timer_ctrl;

  localparam int T  = 4;
  localparam int DC = 6;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_data = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;
  logic       zero;
  logic [3:0] cnt_data;
  logic       cnt_loadn;
  logic       cnt_clrn;
  logic       cnt_enable;
  logic       mag_on;
  logic       done;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  microwave_timer_ctrl #(
    .TICKS_PER_SEC(T),
    .DONE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .key_valid(key_valid),
    .key_data(key_data),
    .start(start),
    .stop(stop),
    .door_closed(door_closed),
    .zero(zero),
    .cnt_data(cnt_data),
    .cnt_loadn(cnt_loadn),
    .cnt_clrn(cnt_clrn),
    .cnt_enable(cnt_enable),
    .mag_on(mag_on),
    .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // counter chain: ones, tens (0-5 on borrow), minutes
  logic [3:0] d0, d1, d2;
  always @(posedge clk or negedge cnt_clrn) begin
    if (!cnt_clrn) begin
      d0 <= 4'd0; d1 <= 4'd0; d2 <= 4'd0;
    end else if (!cnt_loadn) begin
      d2 <= d1; d1 <= d0; d0 <= cnt_data;
    end else if (cnt_enable && !zero) begin
      if (d0 != 4'd0) d0 <= d0 - 4'd1;
      else begin
        d0 <= 4'd9;
        if (d1 != 4'd0) d1 <= d1 - 4'd1;
        else begin
          d1 <= 4'd5;
          d2 <= d2 - 4'd1;
        end
      end
    end
  end
  assign zero = (d0 == 4'd0) && (d1 == 4'd0) && (d2 == 4'd0);

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sp;
    logic       door;
    logic [2:0] es;
    logic       eld;
    logic [3:0] ed;
    logic       eclr;
    logic       een;
    logic       emag;
    logic       edone;
  } vec_t;

  vec_t vec[$];

  function automatic void r(input logic kv, input logic [3:0] kd,
    input logic st, input logic sp, input logic door,
    input logic [2:0] es, input logic eld, input logic [3:0] ed,
    input logic eclr, input logic een, input logic emag,
    input logic edone);
    vec_t v;
    v.kv = kv; v.kd = kd; v.st = st; v.sp = sp; v.door = door;
    v.es = es; v.eld = eld; v.ed = ed; v.eclr = eclr;
    v.een = een; v.emag = emag; v.edone = edone;
    vec.push_back(v);
  endfunction

  task automatic check_all(input string p, input logic [2:0] es,
    input logic eld, input logic [3:0] ed, input logic eclr,
    input logic een, input logic emag, input logic edone);
    chk({p, "_state"}, 8'(state_dbg), 8'(es));
    chk({p, "_loadn"}, 8'(cnt_loadn), 8'(eld));
    chk({p, "_data"}, 8'(cnt_data), 8'(ed));
    chk({p, "_clrn"}, 8'(cnt_clrn), 8'(eclr));
    chk({p, "_enable"}, 8'(cnt_enable), 8'(een));
    chk({p, "_mag"}, 8'(mag_on), 8'(emag));
    chk({p, "_done"}, 8'(done), 8'(edone));
  endtask

  // behavioural model state
  int m_st, m_tick, m_rem, m_data;
  bit m_loadp, m_clr;
  int m_q[$];

  initial begin
    // keys 1,3,0 then a rejected 4th key, then cancel
    r(1,1,0,0,1, 0,1,0,1,0,0,0);
    r(1,3,0,0,1, 1,0,1,1,0,0,0);
    r(1,0,0,0,1, 1,0,3,1,0,0,0);
    r(1,7,0,0,1, 1,0,0,1,0,0,0);
    r(0,0,0,0,1, 1,1,0,1,0,0,0);
    r(0,0,0,1,1, 1,1,0,1,0,0,0);
    r(0,0,0,0,1, 0,1,0,0,0,0,0);
    r(0,0,0,0,1, 0,1,0,1,0,0,0);
    // cook "5" to completion
    r(1,5,0,0,1, 0,1,0,1,0,0,0);
    r(0,0,0,0,1, 1,0,5,1,0,0,0);
    r(0,0,1,0,1, 1,1,5,1,0,0,0);
    for (int p = 0; p < 5; p++)
      for (int t = 0; t < T; t++)
        r(0,0,0,0,1, 2,1,5,1, (t == T-1),1,0);
    r(0,0,0,0,1, 2,1,5,1,0,1,0);
    for (int i = 0; i < DC; i++)
      r(0,0,0,0,1, 4,1,5,1,0,0,1);
    r(0,0,0,0,1, 0,1,5,1,0,0,0);
    // cook "12", door open at tick 2, resume, stop, cancel
    r(1,1,0,0,1, 0,1,5,1,0,0,0);
    r(1,2,0,0,1, 1,0,1,1,0,0,0);
    r(0,0,0,0,1, 1,0,2,1,0,0,0);
    r(0,0,1,0,1, 1,1,2,1,0,0,0);
    r(0,0,0,0,1, 2,1,2,1,0,1,0);
    r(0,0,0,0,1, 2,1,2,1,0,1,0);
    r(0,0,0,0,0, 2,1,2,1,0,0,0);
    r(0,0,0,0,0, 3,1,2,1,0,0,0);
    r(0,0,0,0,1, 3,1,2,1,0,0,0);
    r(0,0,1,0,1, 3,1,2,1,0,0,0);
    r(0,0,0,0,1, 2,1,2,1,0,1,0);
    r(0,0,0,0,1, 2,1,2,1,1,1,0);
    r(0,0,0,1,1, 2,1,2,1,0,1,0);
    r(0,0,0,0,1, 3,1,2,1,0,0,0);
    r(0,0,0,1,1, 3,1,2,1,0,0,0);
    r(0,0,0,0,1, 0,1,2,0,0,0,0);
    r(0,0,0,0,1, 0,1,2,1,0,0,0);
    // start+stop together in ENTRY
    r(1,4,0,0,1, 0,1,2,1,0,0,0);
    r(0,0,0,0,1, 1,0,4,1,0,0,0);
    r(0,0,1,1,1, 1,1,4,1,0,0,0);
    r(0,0,0,0,1, 0,1,4,0,0,0,0);
    r(0,0,0,0,1, 0,1,4,1,0,0,0);
    // start blocked by zero, then by open door; key 12 rejected
    r(1,0,0,0,1, 0,1,4,1,0,0,0);
    r(0,0,0,0,1, 1,0,0,1,0,0,0);
    r(0,0,1,0,1, 1,1,0,1,0,0,0);
    r(0,0,0,0,1, 1,1,0,1,0,0,0);
    r(1,3,0,0,1, 1,1,0,1,0,0,0);
    r(0,0,0,0,1, 1,0,3,1,0,0,0);
    r(0,0,1,0,0, 1,1,3,1,0,0,0);
    r(0,0,0,0,1, 1,1,3,1,0,0,0);
    r(1,12,0,0,1, 1,1,3,1,0,0,0);
    r(0,0,0,0,1, 1,1,3,1,0,0,0);
    r(0,0,0,1,1, 1,1,3,1,0,0,0);
    r(0,0,0,0,1, 0,1,3,0,0,0,0);
    r(0,0,0,0,1, 0,1,3,1,0,0,0);
    // cook "1", key during DONE exits without loading
    r(1,1,0,0,1, 0,1,3,1,0,0,0);
    r(0,0,0,0,1, 1,0,1,1,0,0,0);
    r(0,0,1,0,1, 1,1,1,1,0,0,0);
    for (int t = 0; t < T; t++)
      r(0,0,0,0,1, 2,1,1,1, (t == T-1),1,0);
    r(0,0,0,0,1, 2,1,1,1,0,1,0);
    r(1,5,0,0,1, 4,1,1,1,0,0,1);
    r(0,0,0,0,1, 0,1,1,1,0,0,0);
    r(0,0,0,0,1, 0,1,1,1,0,0,0);

    // reset values while clrn is low
    @(negedge clk);
    @(negedge clk);
    #1 check_all("rst", 0,1,0,0,0,0,0);
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      key_valid = vec[i].kv; key_data = vec[i].kd;
      start = vec[i].st; stop = vec[i].sp;
      door_closed = vec[i].door;
      #1 check_all($sformatf("row%0d", i), vec[i].es, vec[i].eld,
        vec[i].ed, vec[i].eclr, vec[i].een, vec[i].emag, vec[i].edone);
    end

    // reset asserted mid-cook
    @(negedge clk);
    key_valid = 1'b1; key_data = 4'd2; start = 1'b0; stop = 1'b0;
    door_closed = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("f_cook_state", 8'(state_dbg), 8'd2);
    chk("f_cook_mag", 8'(mag_on), 8'd1);
    #2 clrn = 1'b0;
    #1 chk("f_rst_mag", 8'(mag_on), 8'd0);
    chk("f_rst_clrn", 8'(cnt_clrn), 8'd0);
    chk("f_rst_state", 8'(state_dbg), 8'd0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    #1 check_all("f_post", 0,1,0,1,0,0,0);
    chk("f_chain_zero", 8'(zero), 8'd1);

    // random phase against the model
    m_st = 0; m_tick = 0; m_rem = 0; m_data = 0;
    m_loadp = 0; m_clr = 0; m_q.delete();
    for (int c = 0; c < 4000; c++) begin
      bit acc;
      bit kv, st, sp, dr, z;
      int kd;
      @(negedge clk);
      kv = ($urandom_range(0, 5) == 0);
      kd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                       : $urandom_range(0, 2);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 24) == 0);
      dr = ($urandom_range(0, 19) != 0);
      key_valid = kv; key_data = 4'(kd); start = st; stop = sp;
      door_closed = dr;
      #1;
      z = zero;
      check_all("rnd", 3'(m_st), !m_loadp, 4'(m_data), !m_clr,
        (m_st == 2) && dr && (m_tick == T-1), (m_st == 2) && dr,
        (m_st == 4));
      // next-cycle behaviour
      acc = (m_st == 0 || m_st == 1) && kv && kd <= 9 &&
            m_q.size() < 3 && !(m_st == 1 && sp);
      m_loadp = acc;
      m_clr = 0;
      if (acc) begin
        m_data = kd;
        m_q.push_back(kd);
      end
      case (m_st)
        0: if (acc) m_st = 1;
        1: begin
          if (sp) begin
            m_clr = 1; m_q.delete(); m_st = 0;
          end else if (st && dr && !z) m_st = 2;
        end
        2: begin
          if (z) begin
            m_st = 4; m_tick = 0; m_q.delete(); m_rem = DC;
          end else if (sp || !dr) m_st = 3;
          else m_tick = (m_tick + 1) % T;
        end
        3: begin
          if (sp) begin
            m_clr = 1; m_q.delete(); m_tick = 0; m_st = 0;
          end else if (st && dr && !z) m_st = 2;
        end
        default: begin
          m_rem = m_rem - 1;
          if (kv || sp || m_rem == 0) m_st = 0;
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
